twiddle_seq_gen: RTL and testbench

- Parametrised, stage-aware twiddle-factor sequencer for the radix-2 FFT/IFFT datapath. It is the sequential successor to the fixed 4-entry twiddle ROMs.
- On a start command it streams the complete twiddle sequence W_N^(k*2^s) for one butterfly stage s, using a valid/ready handshake.
- It supports forward and inverse (conjugate) mode and sits between the stage controller and the butterfly unit.

---
 rtl/twiddle_seq_gen.sv | 205 ++++++++++++++++++++
 tb/tb_twiddle_seq_gen.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_seq_gen.sv
// Twiddle sequencer: streams W_N^(k*2^s) for one radix-2 stage on start; TW_BITREV_EN selects bit-reversed k order.
// Latency: first entry valid 1 cycle after the accepted start, then 1 entry/cycle under continuous ready.
// Backpressure: tw_valid/tw_ready; while stalled every output is held; start while busy is ignored.
module twiddle_seq_gen #(
    parameter int N_LOG2   = 5,
    parameter int TW_W     = 12,
    parameter int Q        = 10,
    parameter     ROM_FILE = "tw_n32_q10.hex"
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic [3:0]               i_stage,
    input  logic                     i_inverse,
    output logic                     o_busy,
    output logic                     o_err,
    output logic                     o_tw_valid,
    input  logic                     i_tw_ready,
    output logic signed [TW_W-1:0]   o_tw_real,
    output logic signed [TW_W-1:0]   o_tw_imag,
    output logic [N_LOG2-1:0]        o_tw_index,
    output logic                     o_tw_last
);

    localparam int     N       = 1 << N_LOG2;
    localparam int     HALF    = N / 2;
    localparam longint PI_Q30  = 64'sd3373259426;

    generate
        if (Q > TW_W - 2) begin : g_bad_q
            $error("twiddle_seq_gen: Q must not exceed TW_W-2");
        end
        if (N_LOG2 < 2 || N_LOG2 > 10 || $bits(ROM_FILE) == 0) begin : g_bad_n
            $error("twiddle_seq_gen: N_LOG2 outside 2..10 or empty ROM_FILE");
        end
    endgenerate

    // Elaboration-time image of the ROM_FILE contents: fixed-point Taylor series on the
    // first-quadrant angle, magnitudes rounded half away from zero, then quadrant signs.
    function automatic logic [2*TW_W-1:0] rom_entry(input int e);
        longint a, x2, c, s, tc, ts, cq, sq, re, im;
        int     quarter, qd, r;
        quarter = N / 4;
        qd      = e / quarter;
        r       = e % quarter;
        a       = (2 * PI_Q30 * longint'(r)) >>> N_LOG2;
        x2      = (a * a) >>> 30;
        c       = 0;
        s       = 0;
        tc      = 64'sd1 <<< 30;
        ts      = a;
        for (int n = 0; n < 12; n++) begin
            c  = c + tc;
            s  = s + ts;
            tc = -((tc * x2) >>> 30) / longint'((2*n+1) * (2*n+2));
            ts = -((ts * x2) >>> 30) / longint'((2*n+2) * (2*n+3));
        end
        if (c < 0) c = 0;
        if (s < 0) s = 0;
        cq = ((c <<< Q) + (64'sd1 <<< 29)) >>> 30;
        sq = ((s <<< Q) + (64'sd1 <<< 29)) >>> 30;
        if (qd == 0) begin
            re = cq;
            im = -sq;
        end else begin
            re = -sq;
            im = -cq;
        end
        return {re[TW_W-1:0], im[TW_W-1:0]};
    endfunction

    logic [2*TW_W-1:0] w_rom [HALF];

    generate
        for (genvar g = 0; g < HALF; g++) begin : g_rom
            localparam logic [2*TW_W-1:0] P_ENTRY = rom_entry(g);
            assign w_rom[g] = P_ENTRY;
        end
    endgenerate

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                   r_state, w_state_nxt;
    logic [N_LOG2-1:0]        r_k, w_k_nxt;
    logic [3:0]               r_stage, w_stage_nxt;
    logic                     r_inv, w_inv_nxt;
    logic                     r_busy, w_busy_nxt;
    logic                     r_err, w_err_nxt;
    logic                     r_valid, w_valid_nxt;
    logic                     r_last;
    logic                     w_load, w_done;
    logic                     w_illegal;
    logic signed [TW_W-1:0]   r_real, r_imag;
    logic [N_LOG2-1:0]        r_index;
    logic [N_LOG2-1:0]        w_e, w_mlast;
    logic [2*TW_W-1:0]        w_entry;
    logic signed [TW_W-1:0]   w_rom_re, w_rom_im, w_imag_sel;

    assign w_illegal = (32'(i_stage) >= N_LOG2);

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_stage_nxt = r_stage;
        w_inv_nxt   = r_inv;
        w_busy_nxt  = r_busy;
        w_err_nxt   = 1'b0;
        w_valid_nxt = r_valid;
        w_load      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (w_illegal) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_stage_nxt = i_stage;
                        w_inv_nxt   = i_inverse;
                        w_k_nxt     = '0;
                        w_busy_nxt  = 1'b1;
                        w_valid_nxt = 1'b1;
                        w_load      = 1'b1;
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (r_valid && i_tw_ready) begin
                    if (r_last) begin
                        w_valid_nxt = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_done      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_k_nxt = r_k + 1'b1;
                        w_load  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_mlast = N_LOG2'((N >> (32'(w_stage_nxt) + 1)) - 1);

`ifdef TW_BITREV_EN
    // Reversing all N_LOG2 bits then dropping s+1 LSBs reverses k over log2(m) bits.
    logic [N_LOG2-1:0] w_krev;
    always_comb begin
        w_krev = '0;
        for (int i = 0; i < N_LOG2; i++) begin
            w_krev[i] = w_k_nxt[N_LOG2-1-i];
        end
    end
    assign w_e = (w_krev >> (5'(w_stage_nxt) + 5'd1)) << w_stage_nxt;
`else
    assign w_e = w_k_nxt << w_stage_nxt;
`endif

    assign w_entry    = w_rom[w_e[N_LOG2-2:0]];
    assign w_rom_re   = w_entry[2*TW_W-1:TW_W];
    assign w_rom_im   = w_entry[TW_W-1:0];
    assign w_imag_sel = w_inv_nxt ? -w_rom_im : w_rom_im;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_stage <= '0;
            r_inv   <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_real  <= '0;
            r_imag  <= '0;
            r_index <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_stage <= w_stage_nxt;
            r_inv   <= w_inv_nxt;
            r_busy  <= w_busy_nxt;
            r_err   <= w_err_nxt;
            r_valid <= w_valid_nxt;
            if (w_load) begin
                r_real  <= w_rom_re;
                r_imag  <= w_imag_sel;
                r_index <= w_e;
                r_last  <= (w_k_nxt == w_mlast);
            end else if (w_done) begin
                r_last  <= 1'b0;
            end
        end
    end

    assign o_busy     = r_busy;
    assign o_err      = r_err;
    assign o_tw_valid = r_valid;
    assign o_tw_real  = r_real;
    assign o_tw_imag  = r_imag;
    assign o_tw_index = r_index;
    assign o_tw_last  = r_last;

endmodule

// File: tb/tb_twiddle_seq_gen.sv
// Bench for twiddle_seq_gen (N=32, Q=10): randomized stalls checked against a real-arithmetic twiddle model.
module tb_twiddle_seq_gen;

    localparam int  NL   = 5;
    localparam int  N    = 32;
    localparam int  TW_W = 12;
    localparam real PI   = 3.14159265358979323846;

    logic                   clk;
    logic                   rst_n;
    logic                   start;
    logic [3:0]             stage;
    logic                   inverse;
    logic                   busy;
    logic                   err;
    logic                   tw_valid;
    logic                   tw_ready;
    logic signed [TW_W-1:0] tw_real;
    logic signed [TW_W-1:0] tw_imag;
    logic [NL-1:0]          tw_index;
    logic                   tw_last;

    int n_chk;
    int n_err;

    int got_re  [64];
    int got_im  [64];
    int got_e   [64];
    int got_cyc [64];
    bit got_last[64];
    int ref_re_a[64];
    int ref_im_a[64];
    int ref_e_a [64];

    twiddle_seq_gen #(.N_LOG2(NL), .TW_W(TW_W), .Q(10), .ROM_FILE("tw_n32_q10.hex")) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_stage    (stage),
        .i_inverse  (inverse),
        .o_busy     (busy),
        .o_err      (err),
        .o_tw_valid (tw_valid),
        .i_tw_ready (tw_ready),
        .o_tw_real  (tw_real),
        .o_tw_imag  (tw_imag),
        .o_tw_index (tw_index),
        .o_tw_last  (tw_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(-x + 0.5);
    endfunction

    function automatic int ref_re(input int e);
        return rnd(1024.0 * $cos(2.0 * PI * e / N));
    endfunction

    function automatic int ref_im(input int e, input bit inv);
        int v;
        v = -rnd(1024.0 * $sin(2.0 * PI * e / N));
        return inv ? -v : v;
    endfunction

    function automatic int ref_e(input int s, input int k);
`ifdef TW_BITREV_EN
        int mb, r;
        mb = NL - 1 - s;
        r  = 0;
        for (int i = 0; i < mb; i++) r |= ((k >> i) & 1) << (mb - 1 - i);
        return r << s;
`else
        return k << s;
`endif
    endfunction

    // Runs one stage: randomly stalls, optionally pokes start mid-stream, records every handshake
    // and checks stall stability, the cycle budget and the whole sequence against the model.
    task automatic do_stage(input int s, input bit inv, input int stall_pct, input bit poke, output int ne);
        int  cyc, m;
        bit  done, held, rdy;
        int  h_re, h_im, h_e;
        bit  h_last;
        m    = N >> (s + 1);
        ne   = 0;
        done = 0;
        held = 0;
        cyc  = 0;
        @(negedge clk);
        start = 1'b1; stage = 4'(s); inverse = inv; tw_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        n_chk++;
        if (tw_valid !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL first_valid s=%0d: valid=%0b busy=%0b, want 1 1", s, tw_valid, busy);
        end
        while (!done && cyc < 2000) begin
            if (held) begin
                n_chk++;
                if (int'(tw_real) !== h_re || int'(tw_imag) !== h_im || int'(tw_index) !== h_e ||
                    tw_last !== h_last || tw_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL stall_hold s=%0d: got (%0d,%0d,e%0d,l%0b) want (%0d,%0d,e%0d,l%0b)",
                             s, tw_real, tw_imag, tw_index, tw_last, h_re, h_im, h_e, h_last);
                end
            end
            rdy      = ($urandom_range(99) >= stall_pct);
            tw_ready = rdy;
            start    = poke && ($urandom_range(3) == 0);
            stage    = 4'($urandom_range(7));
            if (tw_valid && rdy) begin
                if (ne < 64) begin
                    got_re[ne] = int'(tw_real); got_im[ne] = int'(tw_imag);
                    got_e[ne] = int'(tw_index); got_last[ne] = tw_last; got_cyc[ne] = cyc;
                end
                ne++;
                held = 0;
                if (tw_last) done = 1;
            end else if (tw_valid) begin
                held = 1; h_re = int'(tw_real); h_im = int'(tw_imag); h_e = int'(tw_index); h_last = tw_last;
            end
            @(negedge clk);
            cyc++;
            if (poke) begin
                n_chk++;
                if (err !== 1'b0) begin
                    n_err++;
                    $display("FAIL busy_start_err s=%0d: err=%0b want 0", s, err);
                end
            end
        end
        start = 1'b0; tw_ready = 1'b0;
        n_chk++;
        if (!done) begin
            n_err++;
            $display("FAIL timeout s=%0d: handshakes=%0d want %0d", s, ne, m);
        end
        n_chk++;
        if (busy !== 1'b0 || tw_valid !== 1'b0 || tw_last !== 1'b0) begin
            n_err++;
            $display("FAIL end_state s=%0d: busy=%0b valid=%0b last=%0b want 0 0 0", s, busy, tw_valid, tw_last);
        end
        n_chk++;
        if (ne !== m) begin
            n_err++;
            $display("FAIL count s=%0d: got %0d entries want %0d", s, ne, m);
        end
        for (int i = 0; i < m && i < ne; i++) begin
            n_chk++;
            if (got_e[i] !== ref_e(s, i) || got_re[i] !== ref_re(ref_e(s, i)) ||
                got_im[i] !== ref_im(ref_e(s, i), inv) || got_last[i] !== (i == m - 1)) begin
                n_err++;
                $display("FAIL seq s=%0d inv=%0b [%0d]: got (e%0d,%0d,%0d,l%0b) want (e%0d,%0d,%0d,l%0b)",
                         s, inv, i, got_e[i], got_re[i], got_im[i], got_last[i],
                         ref_e(s, i), ref_re(ref_e(s, i)), ref_im(ref_e(s, i), inv), i == m - 1);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; stage = '0; inverse = 1'b0; tw_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({busy, err, tw_valid, tw_last} !== 4'b0 || tw_real !== '0 || tw_imag !== '0 || tw_index !== '0) begin
            n_err++;
            $display("FAIL reset_state: busy=%0b err=%0b valid=%0b last=%0b re=%0d im=%0d e=%0d want all 0",
                     busy, err, tw_valid, tw_last, tw_real, tw_imag, tw_index);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_stage0_fwd();
        int ne;
        int ke [6] = '{0, 1, 2, 4, 8, 12};
        int kr [6] = '{1024, 1004, 946, 724, 0, -724};
        int ki [6] = '{0, -200, -392, -724, -1024, -724};
        do_stage(0, 1'b0, 0, 1'b0, ne);
        for (int i = 0; i < 16 && i < ne; i++) begin
            n_chk++;
            if (got_cyc[i] !== i) begin
                n_err++;
                $display("FAIL stage0_rate [%0d]: handshake at cycle %0d want %0d", i, got_cyc[i], i);
            end
        end
        for (int j = 0; j < 6; j++) begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 16 && i < ne; i++) begin
                if (got_e[i] == ke[j]) begin
                    seen = 1;
                    n_chk++;
                    if (got_re[i] !== kr[j] || got_im[i] !== ki[j]) begin
                        n_err++;
                        $display("FAIL stage0_value e=%0d: got (%0d,%0d) want (%0d,%0d)",
                                 ke[j], got_re[i], got_im[i], kr[j], ki[j]);
                    end
                end
            end
            n_chk++;
            if (!seen) begin
                n_err++;
                $display("FAIL stage0_missing e=%0d: got absent want present", ke[j]);
            end
        end
        n_chk++;
        if (ne >= 16 && got_e[15] !== 15) begin
            n_err++;
            $display("FAIL stage0_last_e: got e=%0d on last want 15", got_e[15]);
        end
    endtask

    task automatic test_stage2_inv();
        int ne;
        int kr [4] = '{1024, 724, 0, -724};
        int ki [4] = '{0, 724, 1024, 724};
        do_stage(2, 1'b1, 0, 1'b0, ne);
        for (int i = 0; i < 4 && i < ne; i++) begin
            int j;
            j = got_e[i] / 4;
            n_chk++;
            if (j > 3 || got_e[i] % 4 != 0 || got_re[i] !== kr[j] || got_im[i] !== ki[j]) begin
                n_err++;
                $display("FAIL stage2_inv [%0d]: got (e%0d,%0d,%0d) want e multiple of 4 in 0..12 with spec values",
                         i, got_e[i], got_re[i], got_im[i]);
            end
        end
    endtask

    task automatic test_single_entry();
        int ne;
        do_stage(4, 1'b0, 0, 1'b0, ne);
        n_chk++;
        if (ne < 1 || got_e[0] !== 0 || got_re[0] !== 1024 || got_im[0] !== 0 || got_last[0] !== 1'b1 || got_cyc[0] !== 0) begin
            n_err++;
            $display("FAIL single_entry: got (e%0d,%0d,%0d,l%0b,c%0d) want (e0,1024,0,l1,c0)",
                     got_e[0], got_re[0], got_im[0], got_last[0], got_cyc[0]);
        end
    endtask

    task automatic test_illegal_stage();
        @(negedge clk);
        start = 1'b1; stage = 4'd5; inverse = 1'b0;
        @(negedge clk);
        start = 1'b0;
        n_chk++;
        if (err !== 1'b1 || busy !== 1'b0 || tw_valid !== 1'b0) begin
            n_err++;
            $display("FAIL illegal_pulse: err=%0b busy=%0b valid=%0b want 1 0 0", err, busy, tw_valid);
        end
        @(negedge clk);
        n_chk++;
        if (err !== 1'b0 || busy !== 1'b0 || tw_valid !== 1'b0) begin
            n_err++;
            $display("FAIL illegal_after: err=%0b busy=%0b valid=%0b want 0 0 0", err, busy, tw_valid);
        end
    endtask

    task automatic test_stall();
        int ne;
        do_stage(1, 1'b0, 0, 1'b0, ne);
        for (int i = 0; i < 8; i++) begin
            ref_re_a[i] = got_re[i]; ref_im_a[i] = got_im[i]; ref_e_a[i] = got_e[i];
        end
        do_stage(1, 1'b0, 45, 1'b1, ne);
        for (int i = 0; i < 8 && i < ne; i++) begin
            n_chk++;
            if (got_re[i] !== ref_re_a[i] || got_im[i] !== ref_im_a[i] || got_e[i] !== ref_e_a[i]) begin
                n_err++;
                $display("FAIL stall_vs_free [%0d]: got (e%0d,%0d,%0d) want (e%0d,%0d,%0d)",
                         i, got_e[i], got_re[i], got_im[i], ref_e_a[i], ref_re_a[i], ref_im_a[i]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        int ne;
        @(negedge clk);
        start = 1'b1; stage = 4'd0; inverse = 1'b0;
        @(negedge clk);
        start = 1'b0; tw_ready = 1'b1;
        repeat (5) @(negedge clk);
        n_chk++;
        if (tw_valid !== 1'b1 || int'(tw_index) !== ref_e(0, 5)) begin
            n_err++;
            $display("FAIL pre_abort: valid=%0b e=%0d want 1 %0d", tw_valid, tw_index, ref_e(0, 5));
        end
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({busy, err, tw_valid, tw_last} !== 4'b0 || tw_real !== '0 || tw_imag !== '0 || tw_index !== '0) begin
            n_err++;
            $display("FAIL abort_state: busy=%0b valid=%0b last=%0b re=%0d im=%0d e=%0d want all 0",
                     busy, tw_valid, tw_last, tw_real, tw_imag, tw_index);
        end
        tw_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b0 || tw_valid !== 1'b0) begin
            n_err++;
            $display("FAIL post_abort_idle: busy=%0b valid=%0b want 0 0", busy, tw_valid);
        end
        do_stage(0, 1'b0, 20, 1'b0, ne);
        n_chk++;
        if (got_e[0] !== 0) begin
            n_err++;
            $display("FAIL restart_e0: got e=%0d want 0", got_e[0]);
        end
    endtask

    task automatic test_random();
        int ne, s;
        bit inv;
        for (int r = 0; r < 6; r++) begin
            s   = $urandom_range(NL - 1);
            inv = 1'($urandom_range(1));
            do_stage(s, inv, $urandom_range(60), 1'b1, ne);
        end
    endtask

    task automatic test_back_to_back();
        int ne;
        do_stage(3, 1'b1, 0, 1'b0, ne);
        do_stage(3, 1'b0, 0, 1'b0, ne);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        test_reset();
        test_stage0_fwd();
        test_stage2_inv();
        test_single_entry();
        test_illegal_stage();
        test_stall();
        test_reset_midstream();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
